// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, branch flushes and
// data-memory wait stalls with a sticky timeout flag and stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             load_use;

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((if_id_use_rs1 && (id_ex_rd == if_id_rs1)) ||
                     (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

  // When a flush and a write enable are both 1 for the same register, the
  // flush wins in the stage register; the enables here are left as specified.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    timeout_d    = timeout_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    case (state_q)
      ST_INIT: begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          stall_inc    = 1'b1;
          state_d      = ST_MEM_WAIT;
          if (state_q == ST_RUN) begin
            wait_d = 16'd1;
          end else if (wait_q >= TIMEOUT_V) begin
            wait_d = wait_q;
          end else begin
            wait_d = wait_q + 16'd1;
          end
          if (wait_d >= TIMEOUT_V) begin
            timeout_d = 1'b1;
          end
        end else begin
          // Leaving MEM_WAIT applies the RUN rules in the same cycle.
          state_d = ST_RUN;
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end
      default: begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      if (stall_inc) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl (TIMEOUT_CYCLES=4,
// 4-bit counters so counter wrap is reachable), plus an async-reset sequence.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_mem_read, if_id_use_rs1, if_id_use_rs2, branch_taken, mem_busy;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic       if_id_flush, id_ex_flush, mem_timeout;
  logic [3:0] stall_count, flush_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_count(stall_count), .flush_count(flush_count),
    .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, br, mr;
    logic [4:0] rd, rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [1:0] st;
    logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] fl;   // {if_id, id_ex}
    logic [3:0] sc, fc;
    logic       to;
  } vec_t;

  localparam int N = 29;
  vec_t vecs [N];

  function automatic vec_t mk(input logic busy, input logic br, input logic mr,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [1:0] st, input logic [4:0] en, input logic [1:0] fl,
                              input logic [3:0] sc, input logic [3:0] fc, input logic to);
    vec_t v;
    v.busy = busy; v.br = br; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.u1 = u1;
    v.rs2 = rs2; v.u2 = u2; v.st = st; v.en = en; v.fl = fl; v.sc = sc; v.fc = fc; v.to = to;
    return v;
  endfunction

  function automatic logic [17:0] observed();
    return {state, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
            if_id_flush, id_ex_flush, stall_count, flush_count, mem_timeout};
  endfunction

  task automatic drive(input vec_t v);
    mem_busy = v.busy; branch_taken = v.br; id_ex_mem_read = v.mr;
    id_ex_rd = v.rd; if_id_rs1 = v.rs1; if_id_use_rs1 = v.u1;
    if_id_rs2 = v.rs2; if_id_use_rs2 = v.u2;
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    logic [17:0] got;
    got = observed();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got st/en/fl/sc/fc/to=%b expected %b", name, got, exp);
  endtask

  initial begin
    vec_t idle;
    idle = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'b0, 2'b0, 4'd0, 4'd0, 1'b0);
    //            busy  br    mr    rd    rs1   u1    rs2   u2    st     en        fl     sc     fc     to
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'b01111, 2'b11, 4'd0,  4'd0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b11111, 2'b00, 4'd0,  4'd0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 5'b00111, 2'b01, 4'd0,  4'd0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b11111, 2'b00, 4'd1,  4'd0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b01, 5'b11111, 2'b00, 4'd1,  4'd0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 2'b01, 5'b00111, 2'b01, 4'd1,  4'd0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 2'b01, 5'b11111, 2'b00, 4'd2,  4'd0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 2'b01, 5'b11111, 2'b00, 4'd2,  4'd0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 5'b11111, 2'b11, 4'd2,  4'd0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b11111, 2'b00, 4'd2,  4'd1, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b00000, 2'b00, 4'd2,  4'd1, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b10, 5'b00000, 2'b00, 4'd3,  4'd1, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b10, 5'b00000, 2'b00, 4'd4,  4'd1, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b10, 5'b11111, 2'b11, 4'd5,  4'd1, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b11111, 2'b00, 4'd5,  4'd2, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b00000, 2'b00, 4'd5,  4'd2, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b10, 5'b00111, 2'b01, 4'd6,  4'd2, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b11111, 2'b00, 4'd7,  4'd2, 1'b0);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b00000, 2'b00, 4'd7,  4'd2, 1'b0);
    for (int i = 19; i <= 26; i++)
      vecs[i] = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b10, 5'b00000, 2'b00,
                   4'(i - 11), 4'd2, (i >= 22));
    vecs[27] = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b10, 5'b11111, 2'b00, 4'd0,  4'd2, 1'b1);
    vecs[28] = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'b11111, 2'b00, 4'd0,  4'd2, 1'b1);

    // Clock/reset
    rst_n = 1'b0;
    drive(idle);
    @(negedge clk);
    #1 check("reset_init_outputs", {2'b00, 5'b01111, 2'b11, 4'd0, 4'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < N; i++) begin
      drive(vecs[i]);
      #1 check($sformatf("vec%0d", i),
               {vecs[i].st, vecs[i].en, vecs[i].fl, vecs[i].sc, vecs[i].fc, vecs[i].to});
      @(negedge clk);
    end

    // Reset pulse between edges while in MEM_WAIT
    mem_busy = 1'b1;
    @(negedge clk);
    #1 check("enter_mem_wait", {2'b10, 5'b00000, 2'b00, 4'd1, 4'd2, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_wait", {2'b00, 5'b01111, 2'b11, 4'd0, 4'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    mem_busy = 1'b0;
    #1 check("post_reset_init", {2'b00, 5'b01111, 2'b11, 4'd0, 4'd0, 1'b0});
    @(negedge clk);
    #1 check("post_reset_run", {2'b01, 5'b11111, 2'b00, 4'd0, 4'd0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL be the maximum consecutive MEM_WAIT cycles before a timeout is flagged (legal range 1..65535).
REQ-002 Parameter CNT_W, default 32, SHALL be the width of the performance counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 id_ex_mem_read  input  1  SHALL indicate the instruction in ID/EX is a load.
REQ-006 id_ex_rd  input  5  SHALL be the destination register of the ID/EX instruction.
REQ-007 if_id_rs1, if_id_rs2  input  5 each  SHALL be the source registers of the IF/ID instruction.
REQ-008 if_id_use_rs1, if_id_use_rs2  input  1 each  SHALL qualify whether each source register is actually read.
REQ-009 branch_taken  input  1  SHALL indicate EX resolved a taken branch or jump this cycle.
REQ-010 mem_busy  input  1  SHALL indicate data memory cannot complete the MEM-stage access this cycle.
REQ-011 pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  output  1 each  SHALL be stage-register enables (1 = advance).
REQ-012 if_id_flush, id_ex_flush  output  1 each  SHALL insert a bubble into the named register on the next edge.
REQ-013 stall_count, flush_count  output  CNT_W each  SHALL count stall and flush cycles.
REQ-014 mem_timeout  output  1  SHALL be a sticky error flag.
REQ-015 state  output  2  SHALL expose the FSM state (INIT=00, RUN=01, MEM_WAIT=10).

Function
REQ-016 All control outputs SHALL be combinational functions of the registered state and current inputs; counters, mem_timeout and state SHALL be registered.
REQ-017 load_use SHALL be id_ex_mem_read AND id_ex_rd != 0 AND ((if_id_use_rs1 AND id_ex_rd == if_id_rs1) OR (if_id_use_rs2 AND id_ex_rd == if_id_rs2)).
REQ-018 INIT: pc_write=0, if_id_flush=1, id_ex_flush=1, other enables 1; INIT SHALL last exactly one cycle, then go to RUN unconditionally.
REQ-019 RUN priority SHALL be mem_busy > branch_taken > load_use > normal.
REQ-020 RUN with mem_busy=1: all five enables 0, both flushes 0, next state MEM_WAIT, stall_count +1.
REQ-021 RUN with branch_taken=1 (mem_busy=0): all enables 1, if_id_flush=1, id_ex_flush=1, flush_count +1; a coincident load_use SHALL be ignored.
REQ-022 RUN with load_use=1 only: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1, stall_count +1; state stays RUN (single-cycle bubble).
REQ-023 RUN otherwise: all enables 1, flushes 0.
REQ-024 MEM_WAIT with mem_busy=1: outputs as REQ-020, wait counter +1, stall_count +1; branch_taken and load_use SHALL be ignored.
REQ-025 MEM_WAIT with mem_busy=0: state returns to RUN and outputs SHALL be evaluated by RUN rules in the same cycle (zero-cycle exit penalty); wait counter clears.
REQ-026 When the wait counter reaches TIMEOUT_CYCLES while mem_busy=1, mem_timeout SHALL set and remain 1 until reset; the FSM SHALL remain in MEM_WAIT and the wait counter saturates.
REQ-027 A flush SHALL take priority over a write enable for the same register.
REQ-028 stall_count and flush_count SHALL wrap modulo 2^CNT_W.
REQ-029 Outputs SHALL be X-free whenever rst_n=1 and inputs are known.

Reset
REQ-030 rst_n=0 SHALL immediately force state=INIT, stall_count=0, flush_count=0, wait counter=0, mem_timeout=0, regardless of clk.
REQ-031 Reset asserted mid-MEM_WAIT SHALL abandon the wait; first cycle after deassertion SHALL be INIT.
REQ-032 While rst_n=0, control outputs SHALL equal the INIT values of REQ-018.

Verification
REQ-033 Release reset, idle inputs -> cycle 0 state=00, pc_write=0, both flushes 1; cycle 1 state=01, all enables 1.
REQ-034 RUN, id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5, use_rs2=1 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1, stall_count=1; next cycle normal. Repeat with id_ex_rd=0 -> no stall.
REQ-035 RUN, branch_taken=1 with concurrent load_use -> if_id_flush=id_ex_flush=1, pc_write=1, flush_count=1, stall_count unchanged.
REQ-036 mem_busy high 3 cycles then low -> state 10 for cycles 2-3, all enables 0 for 3 cycles, stall_count=3, RUN outputs on the 4th cycle.
REQ-037 TIMEOUT_CYCLES=4, mem_busy held 10 cycles -> mem_timeout=1 after cycle 4, stays 1 after mem_busy drops; only rst_n clears it.
REQ-038 rst_n pulsed low mid-MEM_WAIT between clock edges -> state=00 and counters=0 immediately, before next clk edge.
